// File: rtl/blit_ctl_regs_if.sv
// Bus bundle between the CPU/IO decode and fetch logic and the blitter control register file.
// The master modport drives the strobes and write data; the slave modport is the register file.
interface blit_ctl_regs_if #(
   parameter int unsigned DW     = 8,
   parameter int unsigned NPULSE = 2
);
   logic [DW-1:0]     ID;
   logic              CMDWR;
   logic              LDCMD;
   logic              LDMOD;
   logic              CONWR;
   logic              STRD;
   logic              STOP;
   logic              DONE;
   logic              ICNT_8;
   logic [DW-1:0]     CMD;
   logic [DW-1:0]     MODE;
   logic [NPULSE-1:0] PULSE;
   logic              RUN;
   logic              PAUSED;
   logic [DW-1:0]     DOUT;
   logic              DOE;

   modport master (
      output ID, CMDWR, LDCMD, LDMOD, CONWR, STRD, STOP, DONE, ICNT_8,
      input  CMD, MODE, PULSE, RUN, PAUSED, DOUT, DOE
   );

   modport slave (
      input  ID, CMDWR, LDCMD, LDMOD, CONWR, STRD, STOP, DONE, ICNT_8,
      output CMD, MODE, PULSE, RUN, PAUSED, DOUT, DOE
   );
endinterface

// File: rtl/blit_ctl_regs.sv
// Blitter command/mode registers, RESUME/SRESET pulse generator and run-state FSM.
// All state is clocked on CCLK; the status read-back byte is combinational.
module blit_ctl_regs #(
   parameter int unsigned      DW       = 8,
   parameter int unsigned      NPULSE   = 2,
   parameter logic [DW-1:0]    MODE_RST = {DW{1'b0}}
) (
   input  logic             CCLK,
   input  logic             RESETL,
   blit_ctl_regs_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2
   } state_t;

   state_t            r_state;
   logic [DW-1:0]     r_cmd;
   logic [DW-1:0]     r_mode;
   logic [NPULSE-1:0] r_pulse;
   logic              r_run;
   logic              r_paused;

   logic              w_cmd_ld;
   logic              w_srst;
   logic              w_resume;
   logic [NPULSE-1:0] w_pend_set;

   assign w_cmd_ld   = bus.CMDWR | bus.LDCMD;
   assign w_srst     = r_pulse[1];
   assign w_resume   = r_pulse[0];
   assign w_pend_set = bus.CONWR ? bus.ID[NPULSE:1] : {NPULSE{1'b0}};

   // A live SRESET pulse drops any RESUME requested in the same cycle.
   always_ff @(posedge CCLK or negedge RESETL) begin
      if (!RESETL) begin
         r_pulse <= {NPULSE{1'b0}};
      end else begin
         r_pulse    <= w_pend_set;
         r_pulse[0] <= w_pend_set[0] & ~w_srst;
      end
   end

   // Command register; SRESET and DONE only ever touch the RUN request bit.
   always_ff @(posedge CCLK or negedge RESETL) begin
      if (!RESETL) begin
         r_cmd <= {DW{1'b0}};
      end else if (w_cmd_ld) begin
         r_cmd <= {bus.ID[DW-1:1], bus.ID[0] & ~w_srst};
      end else if (w_srst | bus.DONE) begin
         r_cmd[0] <= 1'b0;
      end
   end

   always_ff @(posedge CCLK or negedge RESETL) begin
      if (!RESETL) begin
         r_mode <= MODE_RST;
      end else if (bus.LDMOD) begin
         r_mode <= bus.ID;
      end
   end

   // Run-state FSM with RUN/PAUSED registered alongside the state.
   always_ff @(posedge CCLK or negedge RESETL) begin
      if (!RESETL) begin
         r_state  <= ST_IDLE;
         r_run    <= 1'b0;
         r_paused <= 1'b0;
      end else if (w_srst) begin
         r_state  <= ST_IDLE;
         r_run    <= 1'b0;
         r_paused <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_ld && bus.ID[0]) begin
                  r_state  <= ST_RUNNING;
                  r_run    <= 1'b1;
                  r_paused <= 1'b0;
               end
            end
            ST_RUNNING: begin
               if (bus.DONE) begin
                  r_state  <= ST_IDLE;
                  r_run    <= 1'b0;
                  r_paused <= 1'b0;
               end else if (bus.STOP) begin
                  r_state  <= ST_PAUSED;
                  r_run    <= 1'b1;
                  r_paused <= 1'b1;
               end
            end
            ST_PAUSED: begin
               if (w_resume) begin
                  r_state  <= ST_RUNNING;
                  r_run    <= 1'b1;
                  r_paused <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_run    <= 1'b0;
               r_paused <= 1'b0;
            end
         endcase
      end
   end

   assign bus.CMD    = r_cmd;
   assign bus.MODE   = r_mode;
   assign bus.PULSE  = r_pulse;
   assign bus.RUN    = r_run;
   assign bus.PAUSED = r_paused;
   assign bus.DOE    = bus.STRD;
   assign bus.DOUT   = bus.STRD ? {{(DW-3){1'b0}}, bus.ICNT_8, bus.STOP, r_run}
                                : {DW{1'b0}};

endmodule

// File: tb/tb_blit_ctl_regs.sv
// Self-checking bench for blit_ctl_regs: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register file.
module tb_blit_ctl_regs;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   blit_ctl_regs_if #(.DW(8), .NPULSE(2)) bus ();

   blit_ctl_regs #(.DW(8), .NPULSE(2), .MODE_RST(8'h00)) dut (
      .CCLK   (clk),
      .RESETL (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model
   logic [7:0] m_cmd;
   logic [7:0] m_mode;
   logic [1:0] m_pulse;
   string      m_st;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cmd   = 8'h00;
      m_mode  = 8'h00;
      m_pulse = 2'b00;
      m_st    = "IDLE";
   endtask

   task automatic check_all();
      logic       e_run;
      logic [7:0] e_dout;
      e_run  = (m_st != "IDLE");
      e_dout = bus.STRD ? {5'b00000, bus.ICNT_8, bus.STOP, e_run} : 8'h00;
      check_val("cmd",    {24'h0, bus.CMD},  {24'h0, m_cmd});
      check_val("mode",   {24'h0, bus.MODE}, {24'h0, m_mode});
      check_val("pulse",  {30'h0, bus.PULSE}, {30'h0, m_pulse});
      check_val("run",    {31'h0, bus.RUN},  {31'h0, e_run});
      check_val("paused", {31'h0, bus.PAUSED}, {31'h0, (m_st == "PAUSE")});
      check_val("dout",   {24'h0, bus.DOUT}, {24'h0, e_dout});
      check_val("doe",    {31'h0, bus.DOE},  {31'h0, bus.STRD});
   endtask

   task automatic clear_in();
      bus.ID = 8'h00; bus.CMDWR = 1'b0; bus.LDCMD = 1'b0; bus.LDMOD = 1'b0;
      bus.CONWR = 1'b0; bus.STRD = 1'b0; bus.STOP = 1'b0; bus.DONE = 1'b0;
      bus.ICNT_8 = 1'b0;
   endtask

   // One clock: apply rules to the model at the edge, then compare all outputs.
   task automatic cycle();
      logic [1:0] np;
      logic       ld;
      logic       sres;
      logic       resume;
      @(posedge clk);
      ld     = bus.CMDWR | bus.LDCMD;
      sres   = m_pulse[1];
      resume = m_pulse[0];
      np     = bus.CONWR ? bus.ID[2:1] : 2'b00;
      if (sres) np[0] = 1'b0;
      if (ld) m_cmd = bus.ID;
      else if (bus.DONE) m_cmd[0] = 1'b0;
      if (sres) m_cmd[0] = 1'b0;
      if (bus.LDMOD) m_mode = bus.ID;
      if (sres) m_st = "IDLE";
      else if (m_st == "IDLE" && ld && bus.ID[0]) m_st = "RUN";
      else if (m_st == "RUN" && bus.DONE) m_st = "IDLE";
      else if (m_st == "RUN" && bus.STOP) m_st = "PAUSE";
      else if (m_st == "PAUSE" && resume) m_st = "RUN";
      m_pulse = np;
      #1;
      check_all();
   endtask

   task automatic idle_cycle();
      clear_in();
      cycle();
   endtask

   task automatic load_cmd(input logic [7:0] v);
      clear_in();
      bus.CMDWR = 1'b1; bus.ID = v;
      cycle();
      clear_in();
   endtask

   task automatic conwr(input logic [7:0] v);
      clear_in();
      bus.CONWR = 1'b1; bus.ID = v;
      cycle();
      clear_in();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      clear_in();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();

      // CMD load starts a run; DONE ends it and clears only bit 0
      load_cmd(8'h61);
      check_val("t2_cmd", {24'h0, bus.CMD}, 32'h61);
      check_val("t2_run", {31'h0, bus.RUN}, 32'h1);
      idle_cycle();
      bus.DONE = 1'b1;
      cycle();
      clear_in();
      check_val("t2_done_run", {31'h0, bus.RUN}, 32'h0);
      check_val("t2_done_cmd", {24'h0, bus.CMD}, 32'h60);

      // STOP pauses, RESUME pulse restarts
      load_cmd(8'h61);
      bus.STOP = 1'b1;
      cycle();
      clear_in();
      check_val("t3_paused", {31'h0, bus.PAUSED}, 32'h1);
      conwr(8'h02);
      check_val("t3_pulse", {30'h0, bus.PULSE}, 32'h1);
      idle_cycle();
      check_val("t3_pulse_end", {30'h0, bus.PULSE}, 32'h0);
      check_val("t3_run", {31'h0, bus.RUN}, 32'h1);
      check_val("t3_unpaused", {31'h0, bus.PAUSED}, 32'h0);

      // SRESET while running keeps MODE and CMD[7:1]
      clear_in();
      bus.LDMOD = 1'b1; bus.ID = 8'hA5;
      cycle();
      conwr(8'h04);
      check_val("t4_pulse", {30'h0, bus.PULSE}, 32'h2);
      idle_cycle();
      check_val("t4_pulse_end", {30'h0, bus.PULSE}, 32'h0);
      check_val("t4_run", {31'h0, bus.RUN}, 32'h0);
      check_val("t4_cmd", {24'h0, bus.CMD}, 32'h60);
      check_val("t4_mode", {24'h0, bus.MODE}, 32'hA5);

      // both pulses in PAUSED: SRESET wins; then back-to-back RESUME pulses
      load_cmd(8'h61);
      bus.STOP = 1'b1;
      cycle();
      conwr(8'h06);
      check_val("t5_both", {30'h0, bus.PULSE}, 32'h3);
      idle_cycle();
      check_val("t5_idle", {31'h0, bus.RUN}, 32'h0);
      conwr(8'h02);
      check_val("t5_b2b_1", {30'h0, bus.PULSE}, 32'h1);
      conwr(8'h02);
      check_val("t5_b2b_2", {30'h0, bus.PULSE}, 32'h1);
      idle_cycle();

      // load coinciding with SRESET pulse
      conwr(8'h04);
      load_cmd(8'hFF);
      check_val("t5_ld_srst_cmd", {24'h0, bus.CMD}, 32'hFE);
      check_val("t5_ld_srst_run", {31'h0, bus.RUN}, 32'h0);

      // status read-back is combinational
      load_cmd(8'h61);
      bus.STRD = 1'b1; bus.STOP = 1'b1; bus.ICNT_8 = 1'b1;
      #1;
      check_val("t6_dout", {24'h0, bus.DOUT}, 32'h07);
      check_val("t6_doe", {31'h0, bus.DOE}, 32'h1);
      bus.STRD = 1'b0;
      #1;
      check_val("t6_dout_off", {24'h0, bus.DOUT}, 32'h00);
      check_val("t6_doe_off", {31'h0, bus.DOE}, 32'h0);
      clear_in();

      // asynchronous reset in the middle of a run with a pulse live
      idle_cycle();
      conwr(8'h02);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("t1_cmd", {24'h0, bus.CMD}, 32'h00);
      check_val("t1_run", {31'h0, bus.RUN}, 32'h0);
      check_val("t1_pulse", {30'h0, bus.PULSE}, 32'h0);
      #1;
      rst_n = 1'b1;
      idle_cycle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         clear_in();
         bus.ID     = 8'($urandom);
         bus.CMDWR  = ($urandom_range(0, 7) == 0);
         bus.LDCMD  = ($urandom_range(0, 15) == 0);
         bus.LDMOD  = ($urandom_range(0, 7) == 0);
         bus.CONWR  = ($urandom_range(0, 5) == 0);
         bus.STRD   = 1'($urandom);
         bus.STOP   = ($urandom_range(0, 3) == 0);
         bus.ICNT_8 = 1'($urandom);
         bus.DONE   = ($urandom_range(0, 7) == 0) && !(bus.CMDWR || bus.LDCMD);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
